// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - owner encoding and address range helper for the data memory arbiter
package dmem_arb_pkg;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0   = 2'b01;
  localparam logic [1:0] OWN_M1   = 2'b10;

  // A byte address is in range when every bit above the word index is zero; addr[1:0] is ignored.
  function automatic logic in_range(input logic [31:0] addr, input int addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (hi == 32'd0);
  endfunction

endpackage

// File: rtl/dmem_arb_fsm.sv
// rtl/dmem_arb_fsm.sv - grant owner FSM: round-robin with bounded hold under contention
module dmem_arb_fsm
  import dmem_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req,
  input  logic       m1_req,
  output logic [1:0] owner
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(MAX_HOLD - 1);

  // last: 0 = M0 owned most recently, 1 = M1; resets to M1 so M0 wins the first tie
  logic              last;
  logic [HOLD_W-1:0] hold_cnt;

  logic [1:0]        owner_nx;
  logic              last_nx;
  logic [HOLD_W-1:0] hold_nx;
  logic              own_is_m1;
  logic              own_req;
  logic              oth_req;

  always_comb begin
    owner_nx  = owner;
    last_nx   = last;
    hold_nx   = hold_cnt;
    own_is_m1 = (owner == OWN_M1);
    own_req   = own_is_m1 ? m1_req : m0_req;
    oth_req   = own_is_m1 ? m0_req : m1_req;

    case (owner)
      OWN_NONE: begin
        hold_nx = '0;
        if (m0_req && m1_req) begin
          owner_nx = last ? OWN_M0 : OWN_M1;
        end else if (m0_req) begin
          owner_nx = OWN_M0;
        end else if (m1_req) begin
          owner_nx = OWN_M1;
        end
      end
      OWN_M0, OWN_M1: begin
        // While the owner requests it is granted, so every cycle here is an accept.
        if (own_req && (!oth_req || (hold_cnt < HOLD_TOP))) begin
          if (hold_cnt != HOLD_TOP) begin
            hold_nx = hold_cnt + HOLD_W'(1);
          end
        end else begin
          last_nx  = own_is_m1;
          hold_nx  = '0;
          owner_nx = oth_req ? (own_is_m1 ? OWN_M0 : OWN_M1) : OWN_NONE;
        end
      end
      default: begin
        owner_nx = OWN_NONE;
        hold_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner    <= OWN_NONE;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      owner    <= owner_nx;
      last     <= last_nx;
      hold_cnt <= hold_nx;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data memory between the load/store and loader ports
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  logic [1:0] owner;
  logic       sel_m1;
  logic       own_req;
  logic       own_we;
  logic       addr_ok;
  logic       m0_acc;
  logic       m1_acc;

  dmem_arb_fsm #(
    .MAX_HOLD (MAX_HOLD)
  ) u_fsm (
    .clk    (clk),
    .reset  (reset),
    .m0_req (m0_req),
    .m1_req (m1_req),
    .owner  (owner)
  );

  assign m0_gnt = (owner == OWN_M0);
  assign m1_gnt = (owner == OWN_M1);
  assign sel_m1 = m1_gnt;

  assign m0_acc  = m0_gnt & m0_req;
  assign m1_acc  = m1_gnt & m1_req;
  assign own_req = m0_acc | m1_acc;

  // With no owner the port still follows M0; mem_we is what keeps the memory safe.
  assign own_we   = sel_m1 ? m1_we    : m0_we;
  assign mem_addr = sel_m1 ? m1_addr  : m0_addr;
  assign mem_wd   = sel_m1 ? m1_wdata : m0_wdata;
  assign addr_ok  = in_range(mem_addr, ADDR_W);
  assign mem_we   = reset & own_req & own_we & addr_ok;

  always_ff @(posedge clk) begin
    if (!reset) begin
      m0_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_acc;
      m0_err    <= m0_acc & ~addr_ok;
      m1_rvalid <= m1_acc;
      m1_err    <= m1_acc & ~addr_ok;
      // Writes leave rdata untouched; out-of-range reads return zero.
      if (m0_acc && !m0_we) begin
        m0_rdata <= addr_ok ? mem_rd : '0;
      end
      if (m1_acc && !m1_we) begin
        m1_rdata <= addr_ok ? mem_rd : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural data memory
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;

  logic [31:0] mem [64];
  logic        mem_load = 1'b1;

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wd;
    end
  end

  dmem_arbiter #(.ADDR_W(6), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rdata  (m0_rdata),
    .m0_rvalid (m0_rvalid),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rdata  (m1_rdata),
    .m1_rvalid (m1_rvalid),
    .m1_err    (m1_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge clk) begin
    exp_t e;
    check("one-hot gnt", 32'(m0_gnt & m1_gnt), 32'd0);
    if (m0_rvalid) begin
      if (q0.size() == 0) begin
        check("m0 unexpected rvalid", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        check("m0 err", 32'(m0_err), 32'(e.err));
        if (e.chk) check("m0 rdata", m0_rdata, e.data);
      end
    end
    if (m1_rvalid) begin
      if (q1.size() == 0) begin
        check("m1 unexpected rvalid", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check("m1 err", 32'(m1_err), 32'(e.err));
        if (e.chk) check("m1 rdata", m1_rdata, e.data);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // One transfer on master m; exp_lat > 0 also checks negedges from req to gnt.
  task automatic xfer(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic chk, input logic [31:0] exp_d, input logic exp_err,
                      input logic exp_we, input int exp_lat);
    int   n;
    logic g;
    exp_t e;
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      g = (m == 0) ? m0_gnt : m1_gnt;
    end while (!g && n < 20);
    check("gnt timeout", 32'(g), 32'd1);
    if (exp_lat > 0) check("gnt latency", 32'(n), 32'(exp_lat));
    check("mem_we at accept", 32'(mem_we), 32'(exp_we));
    e.chk = chk; e.data = exp_d; e.err = exp_err;
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk);
    #1;
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  initial begin
    exp_t e;
    // Reset held with both masters requesting
    m0_req = 1'b1; m1_req = 1'b1;
    @(posedge clk); #1; mem_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset gnt0", 32'(m0_gnt), 32'd0);
      check("reset gnt1", 32'(m1_gnt), 32'd0);
      check("reset mem_we", 32'(mem_we), 32'd0);
      check("reset rvalid", 32'(m0_rvalid | m1_rvalid), 32'd0);
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0; reset = 1'b1;

    // Single M0 write then read
    xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b1, 2);
    xfer(0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    idle(3);
    check("mem[4] after write", mem[4], 32'hDEAD_BEEF);

    // Contention from a fresh reset: M0 wins the tie, 4 accepts each, alternating
    reset = 1'b0; idle(1); reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    @(negedge clk);
    check("contend first gnt0", 32'(m0_gnt), 32'd0);
    check("contend first gnt1", 32'(m1_gnt), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("contend gnt0", 32'(m0_gnt), 32'(((i / 4) % 2) == 0));
      check("contend gnt1", 32'(m1_gnt), 32'(((i / 4) % 2) == 1));
      if (((i / 4) % 2) == 0) begin
        e.chk = 1'b1; e.data = 32'hDEAD_BEEF; e.err = 1'b0; q0.push_back(e);
      end else begin
        e.chk = 1'b1; e.data = 32'hA500_0008; e.err = 1'b0; q1.push_back(e);
      end
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    idle(3);

    // M1 alone keeps ownership past MAX_HOLD
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h24;
    @(negedge clk);
    check("solo first gnt1", 32'(m1_gnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("solo gnt1", 32'(m1_gnt), 32'd1);
      e.chk = 1'b1; e.data = 32'hA500_0009; e.err = 1'b0; q1.push_back(e);
    end
    @(posedge clk); #1;
    m1_req = 1'b0;
    idle(3);

    // Out-of-range write and read from M1
    xfer(1, 1'b1, 32'h100, 32'h1234_5678, 1'b0, 32'h0, 1'b1, 1'b0, 0);
    xfer(1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 0);
    idle(3);
    check("mem[0] unchanged", mem[0], 32'hA500_0000);

    // Reset asserted during an M0 write accept
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h14; m0_wdata = 32'hCAFE_F00D;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!m0_gnt && n < 20);
      check("rst-mid gnt timeout", 32'(m0_gnt), 32'd1);
    end
    reset = 1'b0;
    #1;
    check("rst-mid mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    m0_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rst-mid rvalid", 32'(m0_rvalid), 32'd0);
    check("rst-mid gnt0", 32'(m0_gnt), 32'd0);
    check("rst-mid gnt1", 32'(m1_gnt), 32'd0);
    idle(2);
    check("mem[5] unchanged", mem[5], 32'hA500_0005);

    idle(4);
    check("m0 scoreboard drained", 32'(q0.size()), 32'd0);
    check("m1 scoreboard drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
